// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage (regfile, decode, ID/EX reg, load-use interlock); define DECODE_BYPASS_EN for write-back bypass
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              id_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_valid, r_rw, r_mr, r_mw;
  logic [DATA_W-1:0] r_rsd, r_rtd, r_imm;
  logic [REG_AW-1:0] r_rs, r_rt, r_dest;
  logic [5:0]        r_op, r_fn;
  logic [5:0]        w_op;
  logic [4:0]        w_rs5, w_rt5, w_rd5;
  logic [15:0]       w_imm16;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dest;
  logic              w_is_r, w_is_i, w_lw, w_sw, w_uses_rt, w_rw;
  logic [DATA_W-1:0] w_imm, w_rsd, w_rtd;
  logic              w_wb, w_stall, w_adv;
  assign w_op      = if_instr[31:26];
  assign w_rs5     = if_instr[25:21];
  assign w_rt5     = if_instr[20:16];
  assign w_rd5     = if_instr[15:11];
  assign w_imm16   = if_instr[15:0];
  assign w_rs      = REG_AW'(w_rs5);
  assign w_rt      = REG_AW'(w_rt5);
  assign w_rd      = REG_AW'(w_rd5);
  assign w_is_r    = w_op == 6'h00;
  assign w_is_i    = w_op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
  assign w_lw      = w_op == 6'h23;
  assign w_sw      = w_op == 6'h2B;
  assign w_uses_rt = w_op inside {6'h00, 6'h2B, 6'h04, 6'h05};
  assign w_dest    = w_is_r ? w_rd : (w_is_i || w_lw) ? w_rt : '0;
  assign w_rw      = (w_is_r || w_is_i || w_lw) && w_dest != '0;
  assign w_imm     = (w_op inside {6'h0C, 6'h0D}) ? DATA_W'(w_imm16) : DATA_W'($signed(w_imm16));
  assign w_wb      = wb_en && wb_addr != '0;
`ifdef DECODE_BYPASS_EN
  assign w_rsd = (w_rs == '0) ? '0 : (w_wb && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
  assign w_rtd = (w_rt == '0) ? '0 : (w_wb && wb_addr == w_rt) ? wb_data : r_regs[w_rt];
`else
  assign w_rsd = (w_rs == '0) ? '0 : r_regs[w_rs];
  assign w_rtd = (w_rt == '0) ? '0 : r_regs[w_rt];
`endif
  assign w_stall  = r_valid && r_mr && r_dest != '0 && (r_dest == w_rs || (w_uses_rt && r_dest == w_rt));
  assign w_adv    = !r_valid || ex_ready;
  assign id_ready = w_adv && !w_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[wb_addr] <= wb_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_valid, r_rw, r_mr, r_mw} <= '0;
      {r_rsd, r_rtd, r_imm} <= '0;
      {r_rs, r_rt, r_dest} <= '0;
      {r_op, r_fn} <= '0;
    end else if (w_adv) begin
      if (if_valid && !w_stall) begin
        r_valid <= 1'b1;
        r_rw    <= w_rw;
        r_mr    <= w_lw;
        r_mw    <= w_sw;
        r_rsd   <= w_rsd;
        r_rtd   <= w_rtd;
        r_imm   <= w_imm;
        r_rs    <= w_rs;
        r_rt    <= w_rt;
        r_dest  <= w_dest;
        r_op    <= w_op;
        r_fn    <= if_instr[5:0];
      end else begin
        {r_valid, r_rw, r_mr, r_mw} <= '0;
      end
    end
`ifdef DECODE_BYPASS_EN
    else if (w_wb) begin
      if (wb_addr == r_rs) r_rsd <= wb_data;
      if (wb_addr == r_rt) r_rtd <= wb_data;
    end
`endif
  end
  assign ex_valid     = r_valid;
  assign ex_reg_write = r_rw;
  assign ex_mem_read  = r_mr;
  assign ex_mem_write = r_mw;
  assign ex_rs_data   = r_rsd;
  assign ex_rt_data   = r_rtd;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_dest      = r_dest;
  assign ex_opcode    = r_op;
  assign ex_funct     = r_fn;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with a behavioural reference model checked every cycle
module tb_decode_stage;
  logic        clk = 0, rst = 1, if_valid = 0, ex_ready = 1, wb_en = 0;
  logic [31:0] if_instr = 0, wb_data = 0;
  logic [4:0]  wb_addr = 0;
  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [5:0]  ex_opcode, ex_funct;
  int checks = 0, errors = 0;
  logic m_init = 0;
  logic [31:0] bp_abcd, bp_5555;
  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic v, rw, mr, mw;
    logic [31:0] rsd, rtd, imm;
    logic [4:0] rs, rt, dest;
    logic [5:0] op, fn;
  } ex_t;
  ex_t m;
  logic [31:0] mregs [32];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] rd_reg(logic [4:0] i);
    if (i == 0) return 0;
`ifdef DECODE_BYPASS_EN
    if (wb_en && wb_addr == i) return wb_data;
`endif
    return mregs[i];
  endfunction
  function automatic ex_t dec(logic [31:0] ins);
    ex_t d = '0;
    d.v = 1;
    d.op = ins[31:26];
    d.fn = ins[5:0];
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    case (d.op)
      6'h00: begin d.dest = ins[15:11]; d.rw = 1; end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin d.dest = d.rt; d.rw = 1; end
      6'h23: begin d.dest = d.rt; d.rw = 1; d.mr = 1; end
      6'h2B: d.mw = 1;
      default: ;
    endcase
    if (d.dest == 0) d.rw = 0;
    d.imm = (d.op == 6'h0C || d.op == 6'h0D) ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    d.rsd = rd_reg(d.rs);
    d.rtd = rd_reg(d.rt);
    return d;
  endfunction
  function automatic logic hazard(logic [31:0] ins);
    ex_t d = dec(ins);
    logic ur = d.op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    return m.v && m.mr && m.dest != 0 && (m.dest == d.rs || (ur && m.dest == d.rt));
  endfunction
  function automatic ex_t nxt();
    ex_t n = m;
    if (!m.v || ex_ready) begin
      if (if_valid && !hazard(if_instr)) n = dec(if_instr);
      else begin n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; end
    end
`ifdef DECODE_BYPASS_EN
    else if (wb_en && wb_addr != 0) begin
      if (wb_addr == m.rs) n.rsd = wb_data;
      if (wb_addr == m.rt) n.rtd = wb_data;
    end
`endif
    return n;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m <= '0;
      for (int i = 0; i < 32; i++) mregs[i] <= 0;
      m_init <= 1;
    end else begin
      m <= nxt();
      if (wb_en && wb_addr != 0) mregs[wb_addr] <= wb_data;
    end
  end
  always @(negedge clk) begin
    if (m_init) begin
      chk("id_ready", id_ready, !(!m.v || ex_ready) ? 0 : !hazard(if_instr));
      chk("ex_valid", ex_valid, m.v);
      chk("ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, {m.rw, m.mr, m.mw});
      if (m.v) begin
        chk("rs_data", ex_rs_data, m.rsd);
        chk("rt_data", ex_rt_data, m.rtd);
        chk("imm", ex_imm, m.imm);
        chk("idx", {ex_rs, ex_rt, ex_dest}, {m.rs, m.rt, m.dest});
        chk("op_fn", {ex_opcode, ex_funct}, {m.op, m.fn});
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
`ifdef DECODE_BYPASS_EN
    bp_abcd = 32'hABCD; bp_5555 = 32'h5555;
`else
    bp_abcd = 32'h0; bp_5555 = 32'hABCD;
`endif
    step(); step();
    rst = 0;
    step();
    chk("lit_reset_ready", id_ready, 1);
    chk("lit_reset_valid", ex_valid, 0);
    chk("lit_reset_dest", ex_dest, 0);
    wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
    step();
    wb_en = 0; if_valid = 1; if_instr = 32'h00A01820;
    step();
    chk("lit_add_valid", ex_valid, 1);
    chk("lit_add_rs", ex_rs_data, 32'h1234);
    chk("lit_add_rt", ex_rt_data, 0);
    chk("lit_add_dest", ex_dest, 3);
    chk("lit_add_rw", ex_reg_write, 1);
    if_instr = 32'h2002FFFF;
    step();
    chk("lit_addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("lit_addi_dest", ex_dest, 2);
    if_instr = 32'h3402FFFF;
    step();
    chk("lit_ori_imm", ex_imm, 32'h0000FFFF);
    if_instr = 32'hAC240000;
    step();
    chk("lit_sw_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write}, 3'b001);
    if_instr = 32'hFC000000;
    step();
    chk("lit_unk_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, 27'(ex_dest)}, 0);
    if_instr = 32'h8C240000;
    step();
    chk("lit_lw_mr", ex_mem_read, 1);
    if_instr = 32'h00842820;
    #1;
    chk("lit_stall_ready", id_ready, 0);
    step();
    chk("lit_bubble_valid", ex_valid, 0);
    chk("lit_after_bubble_ready", id_ready, 1);
    step();
    chk("lit_add2_valid", ex_valid, 1);
    chk("lit_add2_dest", ex_dest, 5);
    wb_en = 1; wb_addr = 7; wb_data = 32'hABCD; if_instr = 32'h00E04020;
    step();
    chk("lit_bypass_rs", ex_rs_data, bp_abcd);
    wb_en = 0; if_instr = 32'h00E04820;
    step();
    chk("lit_r7_rs", ex_rs_data, 32'hABCD);
    ex_ready = 0; if_instr = 32'h2002FFFF; wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF;
    #1;
    chk("lit_hold_ready", id_ready, 0);
    step();
    step();
    chk("lit_hold_dest", ex_dest, 9);
    wb_addr = 7; wb_data = 32'h5555;
    step();
    chk("lit_hold_rs", ex_rs_data, bp_5555);
    chk("lit_hold_valid", ex_valid, 1);
    ex_ready = 1; wb_en = 0; if_instr = 32'h00005020;
    step();
    chk("lit_r0_rs", ex_rs_data, 0);
    chk("lit_r0_dest", ex_dest, 10);
    rst = 1; wb_en = 1; wb_addr = 3; wb_data = 32'h77;
    step();
    chk("lit_rst_valid", ex_valid, 0);
    chk("lit_rst_rsd", ex_rs_data, 0);
    rst = 0; wb_en = 0; if_instr = 32'h00A71820;
    step();
    chk("lit_rst_r5", ex_rs_data, 0);
    chk("lit_rst_r7", ex_rt_data, 0);
    if_instr = 32'h00600820;
    step();
    chk("lit_rst_r3", ex_rs_data, 0);
    if_valid = 0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
